// File: rtl/eeprom_cmd_seq.sv
// EEPROM command sequencer: queues host requests in a 4-deep FIFO and
// issues them one at a time to a serial EEPROM engine with timeout and gap.
module eeprom_cmd_seq #(
  parameter int TIMEOUT = 4095,
  parameter int GAP     = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [10:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        WR,
  output logic        RD,
  output logic [10:0] ADDR,
  inout  wire  [7:0]  DATA,
  input  logic        ACK
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GMAX = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ISSUE = 5'b00010,
    S_WAIT  = 5'b00100,
    S_RESP  = 5'b01000,
    S_GAP   = 5'b10000
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [10:0] addr;
    logic [7:0]  wdata;
  } ent_t;

  ent_t        mem_q [4];
  logic [1:0]  wp_q;
  logic [1:0]  rp_q;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic        push;
  logic        pop;
  ent_t        head;

  state_t      state_q;
  ent_t        cmd_q;
  logic        wr_q;
  logic        rd_q;
  logic [TW-1:0] tcnt_q;
  logic [GW-1:0] gcnt_q;
  logic        vld_q;
  logic        err_q;
  logic [7:0]  rdata_q;

  assign req_ready = (cnt_q != 3'd4);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == S_IDLE) && (cnt_q != 3'd0);
  assign head      = mem_q[rp_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 3'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp_q  <= 2'd0;
      rp_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) begin
        rp_q <= rp_q + 2'd1;
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            cmd_q   <= head;
            wr_q    <= head.wr;
            rd_q    <= !head.wr;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // ACK takes priority over an expiring timeout
          if (ACK) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= cmd_q.wr ? 8'h00 : DATA;
            vld_q   <= 1'b1;
            state_q <= S_RESP;
          end else if (tcnt_q == TMAX) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= 8'h00;
            vld_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        S_RESP: begin
          gcnt_q  <= '0;
          state_q <= (GAP == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (gcnt_q == GMAX) begin
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign WR        = wr_q;
  assign RD        = rd_q;
  assign ADDR      = cmd_q.addr;
  assign rsp_valid = vld_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign DATA      = wr_q ? cmd_q.wdata : 8'bz;

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// Bench for eeprom_cmd_seq: vector table, directed corners and random
// traffic against a command-level model of the queue and responses.
module tb_eeprom_cmd_seq;

  localparam int TO = 16;
  localparam int GP = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [10:0] req_addr = 11'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        WR;
  logic        RD;
  logic [10:0] ADDR;
  logic        ACK = 1'b0;
  logic        tb_drv = 1'b0;
  logic [7:0]  tb_dat = 8'h0;
  wire  [7:0]  DATA;

  assign DATA = tb_drv ? tb_dat : 8'bz;

  always #5 CLK = ~CLK;

  eeprom_cmd_seq #(.TIMEOUT(TO), .GAP(GP)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .WR(WR), .RD(RD), .ADDR(ADDR), .DATA(DATA), .ACK(ACK)
  );

  // k = WAIT_ACK cycle index at which the engine acks (>= TO: never)
  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [7:0]  wdata;
    int          k;
    logic [7:0]  bus;
    logic        eerr;
    logic [7:0]  erd;
  } cmd_t;

  int   tests = 0;
  int   fails = 0;
  cmd_t q[$];
  cmd_t act;
  cmd_t hcur;
  cmd_t pcmd;
  bit   prst;
  bit   pv;
  bit   active = 1'b0;
  bit   rise;
  bit   exp_iss = 1'b0;
  bit   spur_en = 1'b0;
  int   cyc;
  int   rcyc;
  int   since = GP + 1;
  logic [7:0] hold_rd = 8'h0;
  logic hold_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic cmd_t mk(input logic wr, input logic [10:0] a,
                              input logic [7:0] w, input int k,
                              input logic [7:0] b);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = w; c.k = k; c.bus = b;
    c.eerr = (k >= TO);
    c.erd = (!c.eerr && !wr) ? b : 8'h00;
    return c;
  endfunction

  function automatic cmd_t vec(input logic wr, input logic [10:0] a,
                               input logic [7:0] w, input int k,
                               input logic [7:0] b, input logic ee,
                               input logic [7:0] er);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = w; c.k = k; c.bus = b;
    c.eerr = ee; c.erd = er;
    return c;
  endfunction

  always @(posedge CLK) begin
    prst <= RESET;
    pv   <= req_valid && req_ready && !RESET;
    pcmd <= hcur;
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (prst) begin
        q.delete();
        active = 1'b0; since = GP + 1; exp_iss = 1'b0;
        hold_rd = 8'h0; hold_err = 1'b0;
        chk("rst_wr", 32'(WR), 32'd0);
        chk("rst_rd", 32'(RD), 32'd0);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        ACK = 1'b0; tb_drv = 1'b0;
      end else begin
        if (pv) q.push_back(pcmd);
        if (tb_drv) chk("bus", 32'(DATA), 32'(tb_dat));
        rise = (WR || RD) && !active;
        chk("issue_time", 32'(rise), 32'(exp_iss));
        if (rise) begin
          chk("issue_queued", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            act = q.pop_front();
            active = 1'b1; cyc = 0;
            rcyc = ((act.k < TO) ? act.k : TO - 1) + 2;
          end
        end else if (active) begin
          cyc++;
        end
        if (active && cyc == rcyc) begin
          chk("rsp_vld", 32'(rsp_valid), 32'd1);
          chk("rsp_wrrd", 32'(WR || RD), 32'd0);
          chk("rsp_err", 32'(rsp_err), 32'(act.eerr));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(act.erd));
          hold_rd = act.erd; hold_err = act.eerr;
          active = 1'b0; since = 0;
        end else begin
          if (active) begin
            chk("cmd_wr", 32'(WR), 32'(act.wr));
            chk("cmd_rd", 32'(RD), 32'(!act.wr));
            chk("cmd_addr", 32'(ADDR), 32'(act.addr));
            if (act.wr) chk("cmd_data", 32'(DATA), 32'(act.wdata));
          end else begin
            since++;
          end
          chk("vld_low", 32'(rsp_valid), 32'd0);
          chk("hold_rdata", 32'(rsp_rdata), 32'(hold_rd));
          chk("hold_err", 32'(rsp_err), 32'(hold_err));
        end
        chk("ready", 32'(req_ready), 32'(q.size() < 4));
        exp_iss = !active && since >= GP + 1 && q.size() != 0;
        ACK = 1'b0; tb_drv = 1'b0;
        if (active && act.k < TO && cyc == act.k + 1) begin
          ACK = 1'b1; tb_drv = !act.wr; tb_dat = act.bus;
        end else if (spur_en && (!active || cyc == 0) &&
                     $urandom_range(0, 3) == 0) begin
          ACK = 1'b1;
        end
      end
    end
  end

  task automatic drive(input cmd_t c);
    hcur = c; req_valid = 1'b1;
    req_wr = c.wr; req_addr = c.addr; req_wdata = c.wdata;
  endtask

  task automatic push(input cmd_t c);
    bit ok = 1'b0;
    @(negedge CLK); #1;
    drive(c);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge CLK); #1;
      ok = pv;
    end
    req_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic burst(input int n, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK); #1;
      drive(mk(1'($urandom_range(0, 1)), 11'($urandom), 8'($urandom),
               $urandom_range(0, 5), 8'($urandom)));
      @(posedge CLK); #1;
      if (pv) acc++;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_active();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK); #1;
      ok = active;
    end
    chk("wait_active", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK); #1;
      done = !active && q.size() == 0 && since >= GP + 1;
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  cmd_t tbl[10];
  int   acc;

  initial begin
    tbl[0] = vec(1'b1, 11'h155, 8'hA5, 12, 8'h00, 1'b0, 8'h00);
    tbl[1] = vec(1'b0, 11'h7FF, 8'h5A, 5,  8'h3C, 1'b0, 8'h3C);
    tbl[2] = vec(1'b0, 11'h123, 8'h00, 19, 8'hFF, 1'b1, 8'h00);
    tbl[3] = vec(1'b1, 11'h000, 8'hFF, 19, 8'h00, 1'b1, 8'h00);
    tbl[4] = vec(1'b0, 11'h2AA, 8'h00, 15, 8'h81, 1'b0, 8'h81);
    tbl[5] = vec(1'b1, 11'h7FF, 8'h00, 15, 8'h00, 1'b0, 8'h00);
    tbl[6] = vec(1'b0, 11'h001, 8'h77, 0,  8'hE7, 1'b0, 8'hE7);
    tbl[7] = vec(1'b1, 11'h400, 8'h3C, 16, 8'h00, 1'b1, 8'h00);
    tbl[8] = vec(1'b0, 11'h555, 8'h00, 16, 8'h99, 1'b1, 8'h00);
    tbl[9] = vec(1'b0, 11'h0AA, 8'h00, 14, 8'h42, 1'b0, 8'h42);

    repeat (3) @(negedge CLK);
    #1 RESET = 1'b0;

    for (int i = 0; i < 10; i++) push(tbl[i]);
    wait_idle(2000);

    push(mk(1'b0, 11'h0F0, 8'h11, 19, 8'h00));
    wait_active();
    burst(5, acc);
    chk("burst_accepted", 32'(acc), 32'd4);
    wait_idle(2000);

    push(mk(1'b1, 11'h321, 8'hC3, 19, 8'h00));
    wait_active();
    push(mk(1'b0, 11'h011, 8'h00, 2, 8'h5E));
    push(mk(1'b1, 11'h022, 8'h6D, 3, 8'h00));
    @(negedge CLK); #1;
    RESET = 1'b1;
    drive(mk(1'b1, 11'h033, 8'h44, 1, 8'h00));
    @(negedge CLK); #1;
    RESET = 1'b0; req_valid = 1'b0;
    chk("post_rst_queue", 32'(q.size()), 32'd0);
    repeat (40) @(negedge CLK);
    chk("post_rst_quiet", 32'(active), 32'd0);

    spur_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(mk(1'($urandom_range(0, 1)), 11'($urandom), 8'($urandom),
              ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 19),
              8'($urandom)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    wait_idle(4000);
    spur_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1);
  end

endmodule
